// File: rtl/debounce_pkg.sv
// Shared constants for the input debouncer: FSM state encoding and glitch counter width.
package debounce_pkg;

  typedef enum logic [1:0] {
    STABLE_LO = 2'd0,
    QUAL_HI   = 2'd1,
    STABLE_HI = 2'd2,
    QUAL_LO   = 2'd3
  } deb_state_e;

  localparam int unsigned GLITCH_W = 8;

endpackage

// File: rtl/bit_synchronizer.sv
// Multi-flop synchronizer for a single asynchronous bit, synchronous active-high reset.
module bit_synchronizer #(
  parameter int unsigned SYNC_STAGES = 2
) (
  input  logic clk,
  input  logic rst,
  input  logic d,
  output logic q
);

  logic [SYNC_STAGES-1:0] chain;

  always_ff @(posedge clk) begin
    if (rst) begin
      chain <= '0;
    end else begin
      chain <= {chain[SYNC_STAGES-2:0], d};
    end
  end

  assign q = chain[SYNC_STAGES-1];

endmodule

// File: rtl/input_debouncer.sv
// Debounces a raw asynchronous level: synchronizes it, then accepts a new level only after
// STABLE_CNT consecutive equal samples; shorter excursions are counted as glitches.
module input_debouncer
  import debounce_pkg::*;
#(
  parameter int unsigned SYNC_STAGES = 2,
  parameter int unsigned STABLE_CNT  = 16,
  parameter int unsigned CNT_W       = $clog2(STABLE_CNT)
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                in,
  output logic                out,
  output logic                busy,
  output logic [GLITCH_W-1:0] glitch_cnt
);

  if (SYNC_STAGES < 2 || SYNC_STAGES > 4) begin : g_bad_sync_stages
    $error("input_debouncer: SYNC_STAGES must be in 2..4");
  end
  if (STABLE_CNT < 2 || STABLE_CNT > 65535) begin : g_bad_stable_cnt
    $error("input_debouncer: STABLE_CNT must be in 2..65535");
  end

  localparam logic [CNT_W-1:0] CntLast = CNT_W'(STABLE_CNT - 1);
  localparam logic [GLITCH_W-1:0] GlitchMax = '1;

  logic sync_in;

  bit_synchronizer #(
    .SYNC_STAGES(SYNC_STAGES)
  ) u_sync (
    .clk(clk),
    .rst(rst),
    .d  (in),
    .q  (sync_in)
  );

  deb_state_e          state_q, state_d;
  logic [CNT_W-1:0]    cnt_q, cnt_d;
  logic                out_q, out_d;
  logic                busy_q, busy_d;
  logic [GLITCH_W-1:0] glitch_q, glitch_d;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= STABLE_LO;
      cnt_q    <= '0;
      out_q    <= 1'b0;
      busy_q   <= 1'b0;
      glitch_q <= '0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      out_q    <= out_d;
      busy_q   <= busy_d;
      glitch_q <= glitch_d;
    end
  end

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    out_d    = out_q;
    glitch_d = glitch_q;

    unique case (state_q)
      STABLE_LO: begin
        if (sync_in) begin
          state_d = QUAL_HI;
          cnt_d   = CNT_W'(1);
        end else begin
          cnt_d   = '0;
        end
      end
      QUAL_HI: begin
        if (!sync_in) begin
          state_d = STABLE_LO;
          cnt_d   = '0;
          if (glitch_q != GlitchMax) glitch_d = glitch_q + GLITCH_W'(1);
        end else if (cnt_q == CntLast) begin
          state_d = STABLE_HI;
          cnt_d   = '0;
          out_d   = 1'b1;
        end else begin
          cnt_d   = cnt_q + CNT_W'(1);
        end
      end
      STABLE_HI: begin
        if (!sync_in) begin
          state_d = QUAL_LO;
          cnt_d   = CNT_W'(1);
        end else begin
          cnt_d   = '0;
        end
      end
      QUAL_LO: begin
        if (sync_in) begin
          state_d = STABLE_HI;
          cnt_d   = '0;
          if (glitch_q != GlitchMax) glitch_d = glitch_q + GLITCH_W'(1);
        end else if (cnt_q == CntLast) begin
          state_d = STABLE_LO;
          cnt_d   = '0;
          out_d   = 1'b0;
        end else begin
          cnt_d   = cnt_q + CNT_W'(1);
        end
      end
      default: begin
        state_d = STABLE_LO;
        cnt_d   = '0;
      end
    endcase

    // busy is registered, so it follows the state being entered on this edge
    busy_d = (state_d == QUAL_HI) || (state_d == QUAL_LO);
  end

  assign out        = out_q;
  assign busy       = busy_q;
  assign glitch_cnt = glitch_q;

endmodule

// File: tb/tb_input_debouncer.sv
// Self-checking bench for input_debouncer: directed scenarios plus random pulse trains,
// compared every cycle against a run-length reference model.
module tb_input_debouncer;

  localparam int unsigned SyncStages = 2;
  localparam int unsigned StableCnt  = 4;

  logic       clk;
  logic       rst;
  logic       din;
  logic       out;
  logic       busy;
  logic [7:0] glitch_cnt;

  int unsigned n_checks;
  int unsigned n_errors;

  // Reference model state
  logic        m_pipe [SyncStages];
  logic        m_level;
  int unsigned m_run;
  int unsigned m_glitch;

  input_debouncer #(
    .SYNC_STAGES(SyncStages),
    .STABLE_CNT (StableCnt)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .in        (din),
    .out       (out),
    .busy      (busy),
    .glitch_cnt(glitch_cnt)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic check(input string tag, input int unsigned got, input int unsigned exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", tag, got, exp, $time);
    end
  endtask

  // One clock edge of the reference: the FSM sees the synchronizer output from before the edge.
  task automatic model_edge(input logic v, input logic r);
    logic s;
    if (r) begin
      for (int i = 0; i < SyncStages; i++) m_pipe[i] = 1'b0;
      m_level  = 1'b0;
      m_run    = 0;
      m_glitch = 0;
    end else begin
      s = m_pipe[SyncStages-1];
      for (int i = SyncStages - 1; i > 0; i--) m_pipe[i] = m_pipe[i-1];
      m_pipe[0] = v;
      if (s != m_level) begin
        m_run++;
        if (m_run == StableCnt) begin
          m_level = s;
          m_run   = 0;
        end
      end else begin
        if (m_run > 0 && m_glitch < 255) m_glitch++;
        m_run = 0;
      end
    end
  endtask

  task automatic step(input logic v, input logic r);
    din = v;
    rst = r;
    @(posedge clk);
    #1;
    model_edge(v, r);
    check("model_out", out, m_level);
    check("model_busy", busy, (m_run > 0) ? 1 : 0);
    check("model_glitch", glitch_cnt, m_glitch);
  endtask

  task automatic hold(input logic v, input int unsigned n);
    for (int i = 0; i < n; i++) step(v, 1'b0);
  endtask

  initial begin
    int unsigned len;
    logic        lvl;
    n_checks = 0;
    n_errors = 0;
    din = 1'b1;
    rst = 1'b1;
    for (int i = 0; i < SyncStages; i++) m_pipe[i] = 1'b0;
    m_level  = 1'b0;
    m_run    = 0;
    m_glitch = 0;

    // Reset with input high: everything stays cleared
    for (int i = 0; i < 3; i++) begin
      step(1'b1, 1'b1);
      check("rst_out", out, 0);
      check("rst_busy", busy, 0);
      check("rst_glitch", glitch_cnt, 0);
    end
    step(1'b0, 1'b1);
    hold(1'b0, 6);

    // Clean rise: busy from edge 2, out at edge 5
    for (int e = 0; e <= 6; e++) begin
      step(1'b1, 1'b0);
      if (e == 1) check("rise_busy_e1", busy, 0);
      if (e == 2) check("rise_busy_e2", busy, 1);
      if (e == 4) check("rise_out_e4", out, 0);
      if (e == 5) begin
        check("rise_out_e5", out, 1);
        check("rise_busy_e5", busy, 0);
      end
    end

    // Short low dip while high is rejected
    hold(1'b0, 2);
    hold(1'b1, 8);
    check("dip_out", out, 1);
    check("dip_glitch", glitch_cnt, 1);

    hold(1'b0, 8);
    check("fall_out", out, 0);

    // Three-cycle high pulse is rejected
    hold(1'b1, 3);
    hold(1'b0, 8);
    check("pulse_out", out, 0);
    check("pulse_glitch", glitch_cnt, 2);

    // Reset during qualification, then requalify
    step(1'b0, 1'b1);
    hold(1'b0, 6);
    for (int e = 0; e < 4; e++) step(1'b1, 1'b0);
    step(1'b1, 1'b1);
    check("midrst_out", out, 0);
    check("midrst_busy", busy, 0);
    check("midrst_glitch", glitch_cnt, 0);
    for (int k = 1; k <= 6; k++) begin
      step(1'b1, 1'b0);
      if (k == 5) check("midrst_out_k5", out, 0);
      if (k == 6) check("midrst_out_k6", out, 1);
    end

    // Random pulse trains, occasional reset
    lvl = 1'b1;
    for (int it = 0; it < 120; it++) begin
      if ($urandom_range(0, 19) == 0) begin
        step(lvl, 1'b1);
      end
      lvl = ~lvl;
      len = $urandom_range(1, 7);
      hold(lvl, len);
    end

    // Glitch counter saturation
    step(1'b0, 1'b1);
    hold(1'b0, 6);
    for (int p = 0; p < 300; p++) begin
      hold(1'b1, 3);
      hold(1'b0, 3);
    end
    hold(1'b0, 4);
    check("sat_out", out, 0);
    check("sat_glitch", glitch_cnt, 255);

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
